// File: rtl/fft_frame_loader.sv
// Ping-pong frame loader in front of the FFT core.
// Collects POINT_FFT complex samples from a valid/ready stream into one of two
// banks and presents a completed bank as a parallel frame in natural order.
// While one frame waits to be consumed, the other bank keeps filling.
//
// Ports:
//   clk_i          clock, all logic on the rising edge
//   rst_i          synchronous active-high reset
//   s_valid_i      input sample valid
//   s_ready_o      loader can accept a sample this cycle
//   s_sof_i        start-of-frame marker, qualified by s_valid_i
//   s_data_i       sample, [0] = real, [1] = imag
//   frame_valid_o  complete frame held on frame_o
//   frame_ready_i  downstream consumes the frame this cycle
//   frame_o        frame, element k = k-th accepted sample of the frame
//   drop_o         one-cycle pulse when a partial frame is discarded by SOF
module fft_frame_loader #(
  parameter int unsigned POINT_FFT_POW2 = 4,
  parameter int unsigned FRAC_BITS      = 15,
  localparam int unsigned POINT_FFT     = 1 << POINT_FFT_POW2
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         s_valid_i,
  output logic                                         s_ready_o,
  input  logic                                         s_sof_i,
  input  logic signed [1:0][FRAC_BITS:0]               s_data_i,
  output logic                                         frame_valid_o,
  input  logic                                         frame_ready_i,
  output logic signed [POINT_FFT-1:0][1:0][FRAC_BITS:0] frame_o,
  output logic                                         drop_o
);

  localparam int unsigned IDX_W = POINT_FFT_POW2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(POINT_FFT - 1);

  // Sample storage; contents are deliberately not reset.
  logic [1:0][FRAC_BITS:0] bank_mem [2][POINT_FFT];

  // Control state
  logic [1:0]       bank_full;
  logic             wr_bank;
  logic             rd_bank;
  logic [IDX_W-1:0] wr_idx;
  logic             drop_q;

  // Next-state values
  logic [1:0]       bank_full_n;
  logic             wr_bank_n;
  logic             rd_bank_n;
  logic [IDX_W-1:0] wr_idx_n;
  logic             drop_n;

  // Per-cycle events
  logic             accept;
  logic             resync;
  logic             consume;
  logic [IDX_W-1:0] wr_addr;

  // Ready depends on registers (and reset) only, never on s_valid_i.
  assign s_ready_o     = !rst_i && !bank_full[wr_bank];
  assign frame_valid_o = bank_full[rd_bank];
  assign drop_o        = drop_q;

  assign accept  = s_valid_i && s_ready_o;
  assign consume = frame_valid_o && frame_ready_i;
  // SOF on a fresh frame (wr_idx == 0) is the normal case, not a resync.
  assign resync  = accept && s_sof_i && (wr_idx != '0);
  assign wr_addr = resync ? '0 : wr_idx;

  // Next-state logic; consume and last-sample write always target
  // different banks because a full bank is never written.
  always_comb begin
    bank_full_n = bank_full;
    wr_bank_n   = wr_bank;
    rd_bank_n   = rd_bank;
    wr_idx_n    = wr_idx;
    drop_n      = 1'b0;

    if (consume) begin
      bank_full_n[rd_bank] = 1'b0;
      rd_bank_n            = ~rd_bank;
    end

    if (accept) begin
      if (resync) begin
        wr_idx_n = IDX_W'(1);
        drop_n   = 1'b1;
      end else if (wr_idx == LAST_IDX) begin
        bank_full_n[wr_bank] = 1'b1;
        wr_bank_n            = ~wr_bank;
        wr_idx_n             = '0;
      end else begin
        wr_idx_n = IDX_W'(wr_idx + 1'b1);
      end
    end
  end

  // Control state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bank_full <= '0;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_idx    <= '0;
      drop_q    <= 1'b0;
    end else begin
      bank_full <= bank_full_n;
      wr_bank   <= wr_bank_n;
      rd_bank   <= rd_bank_n;
      wr_idx    <= wr_idx_n;
      drop_q    <= drop_n;
    end
  end

  // Sample write port
  always_ff @(posedge clk_i) begin
    if (accept) begin
      bank_mem[wr_bank][wr_addr] <= s_data_i;
    end
  end

  // Parallel read of the presented bank; stable while it is full.
  always_comb begin
    for (int k = 0; k < POINT_FFT; k++) begin
      frame_o[k] = bank_mem[rd_bank][k];
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
module tb_fft_frame_loader;

  localparam int unsigned PW   = 4;
  localparam int unsigned FB   = 15;
  localparam int unsigned NPT  = 1 << PW;
  localparam int unsigned W    = FB + 1;
  localparam int          LIMIT = 200;

  typedef logic signed [NPT-1:0][1:0][W-1:0] frame_t;

  logic                 clk;
  logic                 rst_i;
  logic                 s_valid_i;
  logic                 s_ready_o;
  logic                 s_sof_i;
  logic signed [1:0][W-1:0] s_data_i;
  logic                 frame_valid_o;
  logic                 frame_ready_i;
  frame_t               frame_o;
  logic                 drop_o;

  int checks = 0;
  int errors = 0;

  // scoreboard model
  frame_t exp_q[$];
  frame_t cur;
  int     widx = 0;
  int     exp_drops = 0;
  int     drop_seen = 0;

  fft_frame_loader #(.POINT_FFT_POW2(PW), .FRAC_BITS(FB)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .s_sof_i      (s_sof_i),
    .s_data_i     (s_data_i),
    .frame_valid_o(frame_valid_o),
    .frame_ready_i(frame_ready_i),
    .frame_o      (frame_o),
    .drop_o       (drop_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (drop_o) drop_seen++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // model update for one accepted sample
  task automatic model_accept(input logic signed [W-1:0] re, input logic signed [W-1:0] im,
                              input logic sof);
    if (sof && widx != 0) begin
      widx = 0;
      exp_drops++;
    end
    cur[widx] = {im, re};
    widx++;
    if (widx == NPT) begin
      exp_q.push_back(cur);
      widx = 0;
    end
  endtask

  // drive one sample, wait (bounded) for acceptance; returns #1 after accept edge
  task automatic send(input logic signed [W-1:0] re, input logic signed [W-1:0] im,
                      input logic sof);
    int n;
    n = 0;
    @(negedge clk);
    s_valid_i = 1'b1;
    s_sof_i   = sof;
    s_data_i  = {im, re};
    while (!s_ready_o && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready_o) begin
      checks++; errors++;
      $display("FAIL send_timeout: s_ready_o=%0b after %0d cycles, required 1", s_ready_o, n);
      s_valid_i = 1'b0;
      return;
    end
    model_accept(re, im, sof);
    @(posedge clk);
    #1;
    s_valid_i = 1'b0;
    s_sof_i   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // wait for a frame, compare with scoreboard head, consume it
  task automatic take(input string name);
    int n;
    frame_t e;
    n = 0;
    @(negedge clk);
    while (!frame_valid_o && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!frame_valid_o || exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_present: frame_valid_o=%0b queued=%0d, required 1 and >0",
               name, frame_valid_o, exp_q.size());
      return;
    end
    e = exp_q.pop_front();
    checks++;
    if (frame_o !== e) begin
      errors++;
      $display("FAIL %s_data: got %h required %h", name, frame_o, e);
    end
    frame_ready_i = 1'b1;
    @(posedge clk);
    #1;
    frame_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    s_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready_o !== 1'b0) begin
      errors++; $display("FAIL rst_ready: got %0b required 0", s_ready_o);
    end
    checks++;
    if (frame_valid_o !== 1'b0) begin
      errors++; $display("FAIL rst_fvalid: got %0b required 0", frame_valid_o);
    end
    rst_i = 1'b0;
    exp_q.delete();
    widx = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (s_ready_o !== 1'b1 || frame_valid_o !== 1'b0 || drop_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: ready=%0b fvalid=%0b drop=%0b required 1 0 0",
               s_ready_o, frame_valid_o, drop_o);
    end
  endtask

  task automatic test_basic();
    for (int k = 0; k < NPT; k++) begin
      send(W'(k * 100), W'(-k), 1'b0);
      if (k < NPT - 1) begin
        checks++;
        if (frame_valid_o !== 1'b0) begin
          errors++; $display("FAIL basic_early: fvalid=%0b at k=%0d required 0", frame_valid_o, k);
        end
      end
    end
    checks++;
    if (frame_valid_o !== 1'b1) begin
      errors++; $display("FAIL basic_latency: fvalid=%0b required 1", frame_valid_o);
    end
    take("basic");
    checks++;
    if (frame_valid_o !== 1'b0) begin
      errors++; $display("FAIL basic_consumed: fvalid=%0b required 0", frame_valid_o);
    end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 2 * NPT; k++) send(W'(k + 1000), W'(-k - 7), 1'b0);
    // sample 33 offered but both banks full
    @(negedge clk);
    s_valid_i = 1'b1;
    s_data_i  = {W'(-2 * NPT - 7), W'(2 * NPT + 1000)};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (s_ready_o !== 1'b0) begin
        errors++; $display("FAIL bp_full_ready: got %0b at i=%0d required 0", s_ready_o, i);
      end
      @(negedge clk);
    end
    take("bp_f0");
    checks++;
    if (frame_valid_o !== 1'b1 || s_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_after_consume: fvalid=%0b ready=%0b required 1 1", frame_valid_o, s_ready_o);
    end
    for (int k = 2 * NPT; k < 3 * NPT; k++) send(W'(k + 1000), W'(-k - 7), 1'b0);
    take("bp_f1");
    take("bp_f2");
    checks++;
    if (frame_valid_o !== 1'b0) begin
      errors++; $display("FAIL bp_drained: fvalid=%0b required 0", frame_valid_o);
    end
  endtask

  task automatic test_bubbles();
    for (int k = 0; k < NPT; k++) begin
      idle($urandom_range(0, 3));
      send(W'(32767), W'(-32768), 1'b0);
      if (k < NPT - 1) begin
        checks++;
        if (frame_valid_o !== 1'b0) begin
          errors++; $display("FAIL bubble_early: fvalid=%0b at k=%0d required 0", frame_valid_o, k);
        end
      end
    end
    take("bubbles");
    checks++;
    if (frame_valid_o !== 1'b0) begin
      errors++; $display("FAIL bubble_once: fvalid=%0b required 0", frame_valid_o);
    end
  endtask

  task automatic test_sof_resync();
    int d0;
    int e0;
    d0 = drop_seen;
    e0 = exp_drops;
    // SOF on a fresh frame is normal
    send(W'(1), W'(1), 1'b1);
    checks++;
    if (drop_o !== 1'b0) begin
      errors++; $display("FAIL sof_fresh_drop: got %0b required 0", drop_o);
    end
    for (int k = 1; k < 5; k++) send(W'(k + 1), W'(k + 1), 1'b0);
    send(W'(7), W'(7), 1'b1);
    checks++;
    if (drop_o !== 1'b1) begin
      errors++; $display("FAIL sof_drop_pulse: got %0b required 1", drop_o);
    end
    for (int k = 1; k < NPT; k++) begin
      send(W'(200 + k), W'(-200 - k), 1'b0);
      if (k == 1) begin
        checks++;
        if (drop_o !== 1'b0) begin
          errors++; $display("FAIL sof_drop_width: got %0b required 0", drop_o);
        end
      end
    end
    take("sof");
    checks++;
    if (drop_seen - d0 != exp_drops - e0 || exp_drops - e0 != 1) begin
      errors++;
      $display("FAIL sof_drop_count: got %0d required %0d", drop_seen - d0, 1);
    end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < NPT + 9; k++) send(W'(k * 3), W'(k * 5), 1'b0);
    checks++;
    if (frame_valid_o !== 1'b1) begin
      errors++; $display("FAIL mid_presented: fvalid=%0b required 1", frame_valid_o);
    end
    do_reset();
    checks++;
    if (s_ready_o !== 1'b1 || frame_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_after_rst: ready=%0b fvalid=%0b required 1 0", s_ready_o, frame_valid_o);
    end
    for (int k = 0; k < NPT; k++) send(W'(-k * 9), W'(k * 11), 1'b0);
    take("mid");
  endtask

  task automatic test_stability();
    frame_t held;
    for (int k = 0; k < NPT; k++) send(W'(500 + k), W'(-500 - k), 1'b0);
    held = exp_q[0];
    for (int k = 0; k < NPT; k++) begin
      send(W'(-1000 - k), W'(1000 + k), 1'b0);
      checks++;
      if (frame_valid_o !== 1'b1 || frame_o !== held) begin
        errors++;
        $display("FAIL stable_stream: k=%0d fvalid=%0b frame %h required %h",
                 k, frame_valid_o, frame_o, held);
      end
    end
    for (int i = 0; i < 4; i++) begin
      idle(1);
      checks++;
      if (frame_valid_o !== 1'b1 || frame_o !== held) begin
        errors++;
        $display("FAIL stable_idle: i=%0d fvalid=%0b frame %h required %h",
                 i, frame_valid_o, frame_o, held);
      end
    end
    take("stable_f0");
    take("stable_f1");
  endtask

  initial begin
    rst_i         = 1'b1;
    s_valid_i     = 1'b0;
    s_sof_i       = 1'b0;
    s_data_i      = '0;
    frame_ready_i = 1'b0;
    cur           = '0;
    idle(3);
    test_reset();
    test_basic();
    test_backpressure();
    test_bubbles();
    test_sof_resync();
    test_reset_mid();
    test_stability();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL leftover_frames: got %0d required 0", exp_q.size());
    end
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
- Upstream neighbour of the 16-point combinational FFT core.
- Accepts a serial stream of complex fixed-point samples over a valid/ready handshake and assembles POINT_FFT consecutive samples into a frame.
- Presents each complete frame as a parallel array in natural order, ready to feed the FFT data input; the FFT does its own bit reversal.
- Ping-pong (two-bank) buffered, so input streaming continues while a finished frame waits to be consumed.

Parameters:
- POINT_FFT_POW2, 4, log2 of frame length
- FRAC_BITS, 15, fraction bits; each component is FRAC_BITS+1 bits signed
- POINT_FFT, 1 << POINT_FFT_POW2, samples per frame (derived; do not override)

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- s_valid_i  in  1  input sample valid
- s_ready_o  out  1  loader can accept a sample this cycle
- s_sof_i  in  1  start-of-frame marker, qualified by s_valid_i
- s_data_i  in  signed [1:0][FRAC_BITS:0]  sample; index 0 = real, 1 = imag
- frame_valid_o  out  1  complete frame held on frame_o
- frame_ready_i  in  1  downstream consumes frame this cycle
- frame_o  out  signed [1:0][FRAC_BITS:0] x [POINT_FFT]  frame; element k = k-th accepted sample
- drop_o  out  1  one-cycle pulse: partial frame discarded by SOF resync

Behaviour:
- Storage: two banks of POINT_FFT complex entries; state:
  - bank_full[1:0]
  - wr_bank, rd_bank (1 bit each)
  - wr_idx (POINT_FFT_POW2 bits)
- Reset (rst_i high at a clock edge):
  - bank_full=0, wr_bank=0, rd_bank=0, wr_idx=0.
  - Outputs: s_ready_o=0 while rst_i high; frame_valid_o=0; drop_o=0.
  - Bank contents are not reset.
  - Reset mid-frame discards everything, including a presented frame.
- Ready: s_ready_o = !rst_i && !bank_full[wr_bank]. Combinational from registers only; never from s_valid_i.
- Accept = s_valid_i && s_ready_o.
- On accept without SOF resync:
  - Write s_data_i to bank[wr_bank][wr_idx].
  - If wr_idx == POINT_FFT-1: set bank_full[wr_bank], toggle wr_bank, set wr_idx=0.
  - Otherwise increment wr_idx.
- SOF resync (accept with s_sof_i=1 and wr_idx != 0):
  - Discard the partial frame.
  - Write the sample to index 0 of the same bank, set wr_idx=1.
  - Pulse drop_o for the following cycle only (registered).
- SOF on a sample with wr_idx == 0 is normal; no drop.
- SOF is not required; free-running streams frame every POINT_FFT samples.
- Output:
  - frame_valid_o = bank_full[rd_bank], registered.
  - frame_o = bank[rd_bank] contents.
  - frame_o is don't-care while frame_valid_o=0, and must be bit-stable while frame_valid_o=1 and not consumed.
- Consume (frame_valid_o && frame_ready_i): clear bank_full[rd_bank], toggle rd_bank.
- Latency: last sample of a frame accepted at edge t → frame_valid_o=1 in the cycle after t (1 cycle).
- Throughput: 1 sample/cycle sustained, provided each frame is consumed within POINT_FFT cycles of presentation.
- Both banks full: s_ready_o=0. A consume at edge t frees that bank, so s_ready_o=1 in the cycle after t.
- Simultaneous last-sample write to bank X and consume of bank Y (X≠Y) in the same edge: both take effect.
- Last-sample write and consume of the same bank in one edge is impossible, since a full bank is never written.
- Frames are delivered strictly in arrival order.
- Arithmetic: none; data passes bit-exact with sign preserved.

Test Plan:
- Reset then 16 back-to-back samples, sample k = {re=k*100, im=-k} → frame_valid_o=1 one cycle after the 16th accept; frame_o[k] = {k*100, -k}; frame_ready_i=1 → frame_valid_o=0 next cycle.
- 48 continuous samples with frame_ready_i held 0:
  - s_ready_o falls after sample 32 and stays low; sample 33 is not accepted.
  - Pulse frame_ready_i → frame 0 consumed, frame 1 presented next cycle, s_ready_o=1; remaining samples fill the freed bank as the third frame.
- Bubbles: s_valid_i toggled randomly over 16 accepted samples {re=32767, im=-32768} → frame_o exact extremes, no sign corruption, frame_valid_o exactly once.
- SOF resync: 5 samples, then a sample with s_sof_i=1 and value {7,7}, then 15 more → drop_o single pulse; frame_o[0]={7,7}; first 5 samples absent.
- Reset mid-operation: one frame presented and 9 samples into the next, assert rst_i one cycle → frame_valid_o=0, s_ready_o=0 during reset; next 16 samples form frame 0 in bank 0.
- Stability: frame presented, frame_ready_i=0 for 20 cycles while new samples stream → frame_o unchanged every cycle until consumed.
